bus_arbiter: RTL and testbench

Parametrised, registered successor to the datapath bus multiplexer. It accepts bus requests from `NSRC` sources, such as registers R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort and C. It grants the bus to one source at a time using round-robin priority with a bounded hold time, and drives the selected source's data onto a registered `bus_out`. It sits between the datapath register outputs and every bus consumer, replacing static one-hot enables with request/grant ownership.

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_rr_picker.sv | 33 +++
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus-arbiter definitions: FSM state type, index-width helper and the
// datapath-wide bus defaults.
package bus_arbiter_pkg;

  localparam int unsigned BUS_WIDTH = 32;
  localparam int unsigned BUS_NSRC  = 24;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } bus_state_e;

  // Never narrower than one bit, so a MAX_HOLD of 1 still gets a counter.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bus between the datapath sources and the arbiter.
// The master side is the sources and consumers; the slave side is the arbiter.
interface bus_arbiter_if import bus_arbiter_pkg::*; #(
  parameter int unsigned WIDTH = BUS_WIDTH,
  parameter int unsigned NSRC  = BUS_NSRC
) ();

  localparam int unsigned IW = idx_w(NSRC);

  logic [NSRC-1:0]       src_req;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       grant;
  logic [IW-1:0]         owner;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;

  modport master (
    output src_req, src_data,
    input  grant, owner, bus_out, bus_valid
  );

  modport slave (
    input  src_req, src_data,
    output grant, owner, bus_out, bus_valid
  );

endinterface

// File: rtl/bus_rr_picker.sv
// Combinational rotating-priority encoder: returns the first requester found
// searching last_i+1, last_i+2, ... modulo NSRC.
module bus_rr_picker import bus_arbiter_pkg::*; #(
  parameter int unsigned NSRC = BUS_NSRC,
  localparam int unsigned IW  = idx_w(NSRC)
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            found_o,
  output logic [IW-1:0]   winner_o
);

  // One spare bit: last_i + k never exceeds 2*NSRC-1.
  logic [IW:0] pos;

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    pos      = '0;
    // Scan farthest-first so the nearest requester after last_i overwrites the rest.
    for (int unsigned k = NSRC; k > 0; k--) begin
      pos = {1'b0, last_i} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(NSRC)) begin
        pos = pos - (IW + 1)'(NSRC);
      end
      if (req_i[pos[IW-1:0]]) begin
        found_o  = 1'b1;
        winner_o = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin bus arbiter with bounded hold time: one owner at a
// time drives its data onto bus_out, lagging the source by one cycle.
module bus_arbiter import bus_arbiter_pkg::*; #(
  parameter int unsigned WIDTH    = BUS_WIDTH,
  parameter int unsigned NSRC     = BUS_NSRC,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic          clock,
  input logic          clear_n,
  bus_arbiter_if.slave arb_bus
);

  localparam int unsigned IW = idx_w(NSRC);
  localparam int unsigned HW = idx_w(MAX_HOLD);

  localparam logic [0:0]    StIdle  = IDLE;
  localparam logic [0:0]    StOwned = OWNED;
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LastRst = IW'(NSRC - 1);

  logic [0:0]       state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [NSRC-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] src_word [NSRC];
  logic             found;
  logic [IW-1:0]    winner;
  logic             owner_req;
  logic             others_req;
  logic             take_new;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign src_word[i] = arb_bus.src_data[i*WIDTH +: WIDTH];
  end

  // While owned, last_q equals the owner, so the owner is searched last.
  bus_rr_picker #(
    .NSRC(NSRC)
  ) u_picker (
    .req_i   (arb_bus.src_req),
    .last_i  (last_q),
    .found_o (found),
    .winner_o(winner)
  );

  always_comb begin
    owner_req  = arb_bus.src_req[owner_q];
    others_req = |(arb_bus.src_req & ~grant_q);
    take_new   = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    bus_d      = bus_q;
    valid_d    = valid_q;

    case (state_q)
      StIdle: take_new = found;
      StOwned: begin
        if (owner_req && !(hold_cnt_q == HoldMax && others_req)) begin
          bus_d = src_word[owner_q];
          if (hold_cnt_q != HoldMax) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end else if (found) begin
          take_new = 1'b1;
        end else begin
          state_d = StIdle;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_new) begin
      state_d    = StOwned;
      owner_d    = winner;
      last_d     = winner;
      grant_d    = NSRC'(1) << winner;
      bus_d      = src_word[winner];
      valid_d    = 1'b1;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      last_q     <= LastRst;
      owner_q    <= '0;
      grant_q    <= '0;
      bus_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      bus_q      <= bus_d;
      valid_q    <= valid_d;
    end
  end

  assign arb_bus.grant     = grant_q;
  assign arb_bus.owner     = owner_q;
  assign arb_bus.bus_out   = bus_q;
  assign arb_bus.bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a behavioural model predicts each edge's
// outputs, which are queued and compared after the edge, plus directed spot checks.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 24;
  localparam int unsigned H = 4;

  logic clk = 1'b0;
  logic clear_n;

  bus_arbiter_if #(.WIDTH(W), .NSRC(N)) bif ();

  bus_arbiter #(
    .WIDTH   (W),
    .NSRC    (N),
    .MAX_HOLD(H)
  ) dut (
    .clock  (clk),
    .clear_n(clear_n),
    .arb_bus(bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [4:0]   owner;
    logic [W-1:0] bus;
    logic         valid;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic         m_valid;
  logic [4:0]   m_last;
  logic [4:0]   m_owner;
  int           m_hold;
  logic [W-1:0] m_bus;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural next-state for the edge that will sample the current inputs.
  task automatic model_step();
    int w;
    bit found;
    bit others;
    if (!clear_n) begin
      m_valid = 1'b0;
      m_last  = 5'(N - 1);
      m_owner = '0;
      m_hold  = 0;
      m_bus   = '0;
      return;
    end
    found = 1'b0;
    w     = 0;
    for (int k = 1; k <= int'(N); k++) begin
      int i;
      i = (int'(m_last) + k) % int'(N);
      if (!found && bif.src_req[i]) begin
        found = 1'b1;
        w     = i;
      end
    end
    others = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (i != int'(m_owner) && bif.src_req[i]) others = 1'b1;
    end
    if (m_valid && bif.src_req[m_owner] && !(m_hold == int'(H) - 1 && others)) begin
      m_bus = bif.src_data[int'(m_owner)*W +: W];
      if (m_hold < int'(H) - 1) m_hold++;
    end else if (found) begin
      m_valid = 1'b1;
      m_owner = w[4:0];
      m_last  = w[4:0];
      m_hold  = 0;
      m_bus   = bif.src_data[w*W +: W];
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    exp_t e;
    exp_t o;
    model_step();
    e.grant = m_valid ? (N'(1) << m_owner) : '0;
    e.owner = m_owner;
    e.bus   = m_bus;
    e.valid = m_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      o = sb.pop_front();
      check_eq("sb_grant", bif.grant, o.grant);
      check_eq("sb_owner", bif.owner, o.owner);
      check_eq("sb_bus", bif.bus_out, o.bus);
      check_eq("sb_valid", bif.bus_valid, o.valid);
    end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bif.src_data[i*W +: W] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_seq [9];
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    // Reset with every source requesting.
    clear_n      = 1'b0;
    bif.src_req  = '1;
    bif.src_data = '0;
    cycle();
    cycle();
    check_eq("rst_grant", bif.grant, 64'd0);
    check_eq("rst_owner", bif.owner, 64'd0);
    check_eq("rst_bus", bif.bus_out, 64'd0);
    check_eq("rst_valid", bif.bus_valid, 64'd0);
    clear_n = 1'b1;
    cycle();
    check_eq("first_owner", bif.owner, 64'd0);
    check_eq("first_grant", bif.grant, 64'h000001);

    // Single source, bus tracks data with one cycle lag.
    bif.src_req = N'(1);
    set_data(0, 32'd12);
    cycle();
    check_eq("single_bus12", bif.bus_out, 64'd12);
    check_eq("single_valid", bif.bus_valid, 64'd1);
    set_data(0, 32'd3);
    cycle();
    check_eq("single_bus3", bif.bus_out, 64'd3);

    // Fairness between sources 0 and 1 starting from the reset pointer.
    clear_n = 1'b0;
    cycle();
    clear_n     = 1'b1;
    bif.src_req = N'(3);
    for (int k = 0; k < 9; k++) begin
      cycle();
      check_eq("fair_owner", bif.owner, 64'(exp_seq[k]));
      check_eq("fair_valid", bif.bus_valid, 64'd1);
    end

    // Owner 0 drops, 1 takes over, then release to idle.
    set_data(1, 32'h1111_1111);
    bif.src_req = N'(2);
    cycle();
    check_eq("handover_owner", bif.owner, 64'd1);
    check_eq("handover_bus", bif.bus_out, 64'h1111_1111);
    bif.src_req = '0;
    set_data(1, 32'h2222_2222);
    cycle();
    check_eq("idle_valid", bif.bus_valid, 64'd0);
    check_eq("idle_grant", bif.grant, 64'd0);
    check_eq("idle_bus_hold", bif.bus_out, 64'h1111_1111);
    bif.src_req = N'(1);
    cycle();
    check_eq("regrant_owner", bif.owner, 64'd0);
    check_eq("regrant_valid", bif.bus_valid, 64'd1);

    // Wrap-around past the top index.
    bif.src_req = N'(1) << 23;
    cycle();
    check_eq("wrap_owner23", bif.owner, 64'd23);
    bif.src_req = N'(1) | (N'(1) << 5);
    cycle();
    check_eq("wrap_owner0", bif.owner, 64'd0);
    bif.src_req = N'(1) << 5;
    cycle();
    check_eq("wrap_owner5", bif.owner, 64'd5);

    // Reset while source 7 owns the bus with hold count 2.
    bif.src_req = N'(1) << 7;
    cycle();
    cycle();
    cycle();
    check_eq("mid_owner7", bif.owner, 64'd7);
    clear_n = 1'b0;
    cycle();
    check_eq("mid_rst_grant", bif.grant, 64'd0);
    check_eq("mid_rst_owner", bif.owner, 64'd0);
    check_eq("mid_rst_bus", bif.bus_out, 64'd0);
    check_eq("mid_rst_valid", bif.bus_valid, 64'd0);
    clear_n     = 1'b1;
    bif.src_req = N'(1) | (N'(1) << 7);
    cycle();
    check_eq("mid_restart_owner", bif.owner, 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      bif.src_req = N'($urandom & $urandom & $urandom);
      for (int i = 0; i < int'(N); i++) set_data(i, $urandom);
      clear_n = ($urandom_range(0, 49) != 0);
      cycle();
    end

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
